// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: PC function-select codes and fetch states.
// Program counter and control logic reuse the PS constants.
package instruction_fetch_pkg;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_REL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_fsm.sv
// Fetch control: state register, next-state, PS/pc_in/mem_req decode.
// Redirects override everything and cancel any fetch result.
import instruction_fetch_pkg::*;

module fetch_ctrl_fsm (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_ack,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic        redirect_mode,
    input  logic [31:0] redirect_value,
    output logic [1:0]  PS,
    output logic [31:0] pc_in,
    output logic        mem_req,
    output logic        inst_valid,
    output logic        req_load,
    output logic        inst_load
);

    fetch_state_t state;
    fetch_state_t next;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= next;
    end

    // Next-state and PC/memory control decode.
    always_comb begin
        next       = state;
        PS         = PS_HOLD;
        pc_in      = '0;
        mem_req    = 1'b0;
        inst_valid = 1'b0;
        req_load   = 1'b0;
        inst_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!redirect_valid) begin
                    req_load = 1'b1;
                    next     = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (redirect_valid) begin
                    next = mem_ack ? ST_IDLE : ST_DRAIN;
                end else if (mem_ack) begin
                    inst_load = 1'b1;
                    PS        = PS_INC;
                    next      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst_valid = 1'b1;
                if (redirect_valid) begin
                    next = ST_IDLE;
                end else if (inst_ready) begin
                    req_load = 1'b1;
                    next     = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Outstanding request cannot be withdrawn; its data is dropped.
                mem_req = 1'b1;
                if (mem_ack) next = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
        if (redirect_valid) begin
            PS    = redirect_mode ? PS_REL : PS_LOAD;
            pc_in = redirect_value;
        end
        if (reset) begin
            PS    = PS_HOLD;
            pc_in = '0;
        end
    end

endmodule

// File: rtl/register_nbit.sv
// Generic N-bit register with synchronous reset to zero and load enable.
module RegisterNbit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Hold value unless loaded; reset wins.
    always_ff @(posedge clock) begin
        if (reset)     q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads PC, fetches from instruction memory, holds the
// word for decode and steers the program counter via PS/pc_in.
import instruction_fetch_pkg::*;

module instruction_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [1:0]  PS,
    output logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic        redirect_mode,
    input  logic [31:0] redirect_value
);

    logic        req_load;
    logic        inst_load;
    logic [31:0] req_addr;

    fetch_ctrl_fsm u_ctrl (
        .clock          (clock),
        .reset          (reset),
        .mem_ack        (mem_ack),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .redirect_value (redirect_value),
        .PS             (PS),
        .pc_in          (pc_in),
        .mem_req        (mem_req),
        .inst_valid     (inst_valid),
        .req_load       (req_load),
        .inst_load      (inst_load)
    );

    RegisterNbit #(.N(32)) u_req_addr (
        .clock (clock),
        .reset (reset),
        .load  (req_load),
        .d     (PC),
        .q     (req_addr)
    );

    RegisterNbit #(.N(32)) u_inst (
        .clock (clock),
        .reset (reset),
        .load  (inst_load),
        .d     (mem_rdata),
        .q     (inst)
    );

    RegisterNbit #(.N(32)) u_inst_pc (
        .clock (clock),
        .reset (reset),
        .load  (inst_load),
        .d     (req_addr),
        .q     (inst_pc)
    );

    assign mem_addr = req_addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural program counter.
// Inputs driven at negedge; outputs sampled 1 ns later.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic [1:0]  PS;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic        redirect_mode;
    logic [31:0] redirect_value;

    int checks = 0;
    int failures = 0;

    instruction_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .PC             (PC),
        .PS             (PS),
        .pc_in          (pc_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .redirect_value (redirect_value)
    );

    always #5 clock = ~clock;

    // Program counter model.
    always @(posedge clock) begin
        if (reset) PC <= 32'd0;
        else begin
            case (PS)
                2'b01: PC <= PC + 32'd4;
                2'b10: PC <= pc_in;
                2'b11: PC <= PC + 32'd4 + (pc_in << 2);
                default: PC <= PC;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic ack,
                       input logic [31:0] rd, input logic rdy,
                       input logic rv, input logic rm,
                       input logic [31:0] rval);
        @(negedge clock);
        reset          = rst;
        mem_ack        = ack;
        mem_rdata      = rd;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_mode  = rm;
        redirect_value = rval;
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 0; mem_rdata = 0; inst_ready = 0;
        redirect_valid = 0; redirect_mode = 0; redirect_value = 0;
        repeat (2) @(posedge clock);
        // Reset cycle: PS forced to hold even with a redirect pending.
        cyc(1, 0, 0, 1, 1, 1, 32'h55);
        chk("rst_ps", {30'd0, PS}, 32'd0);
        chk("rst_pcin", pc_in, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_ipc", inst_pc, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        // Cycle 1: IDLE.
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ps", {30'd0, PS}, 32'd0);

        // Zero-wait fetches at 0,4,8,12.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 32'hA000 + k, 1, 0, 0, 0);
            chk("zw_req", {31'd0, mem_req}, 32'd1);
            chk("zw_addr", mem_addr, 32'(4 * k));
            chk("zw_ps", {30'd0, PS}, 32'd1);
            cyc(0, 0, 0, 1, 0, 0, 0);
            chk("zw_valid", {31'd0, inst_valid}, 32'd1);
            chk("zw_inst", inst, 32'hA000 + k);
            chk("zw_ipc", inst_pc, 32'(4 * k));
            chk("zw_hold_ps", {30'd0, PS}, 32'd0);
            chk("zw_hold_req", {31'd0, mem_req}, 32'd0);
        end

        // Ack delayed 3 cycles at address 16.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("dl_req", {31'd0, mem_req}, 32'd1);
            chk("dl_addr", mem_addr, 32'd16);
            chk("dl_ps", {30'd0, PS}, 32'd0);
        end
        cyc(0, 1, 32'hB0, 0, 0, 0, 0);
        chk("dl_ack_addr", mem_addr, 32'd16);
        chk("dl_ack_ps", {30'd0, PS}, 32'd1);

        // Decode stalls 5 cycles.
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            chk("st_valid", {31'd0, inst_valid}, 32'd1);
            chk("st_inst", inst, 32'hB0);
            chk("st_ipc", inst_pc, 32'd16);
            chk("st_req", {31'd0, mem_req}, 32'd0);
            chk("st_ps", {30'd0, PS}, 32'd0);
        end
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("st_go_valid", {31'd0, inst_valid}, 32'd1);
        cyc(0, 1, 32'hC0, 0, 0, 0, 0);
        chk("st_resume_addr", mem_addr, 32'd20);
        chk("st_resume_ps", {30'd0, PS}, 32'd1);

        // Absolute redirect in HOLD; inst_ready ignored.
        cyc(0, 0, 0, 1, 1, 0, 32'h100);
        chk("abs_ps", {30'd0, PS}, 32'd2);
        chk("abs_pcin", pc_in, 32'h100);
        chk("abs_valid_hold", {31'd0, inst_valid}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("abs_valid_drop", {31'd0, inst_valid}, 32'd0);
        chk("abs_idle_req", {31'd0, mem_req}, 32'd0);
        chk("abs_idle_ps", {30'd0, PS}, 32'd0);
        cyc(0, 1, 32'hD0, 0, 0, 0, 0);
        chk("abs_addr", mem_addr, 32'h100);
        chk("abs_ack_ps", {30'd0, PS}, 32'd1);

        // Steer to 0x20, then relative redirect during unacked REQ.
        cyc(0, 0, 0, 0, 1, 0, 32'h20);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'd3);
        chk("rel_addr", mem_addr, 32'h20);
        chk("rel_ps", {30'd0, PS}, 32'd3);
        chk("rel_pcin", pc_in, 32'd3);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("dr_req", {31'd0, mem_req}, 32'd1);
        chk("dr_addr", mem_addr, 32'h20);
        chk("dr_ps", {30'd0, PS}, 32'd0);
        cyc(0, 1, 32'hDEAD, 0, 0, 0, 0);
        chk("dr_ack_ps", {30'd0, PS}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("dr_idle_req", {31'd0, mem_req}, 32'd0);
        chk("dr_idle_valid", {31'd0, inst_valid}, 32'd0);
        chk("dr_inst_kept", inst, 32'hD0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rel_next_addr", mem_addr, 32'h30);

        // Enter DRAIN again, then reset.
        cyc(0, 0, 0, 0, 1, 0, 32'h40);
        cyc(1, 0, 0, 0, 1, 0, 32'h80);
        chk("rd_ps", {30'd0, PS}, 32'd0);
        chk("rd_pcin", pc_in, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rd_req", {31'd0, mem_req}, 32'd0);
        chk("rd_addr", mem_addr, 32'd0);
        chk("rd_inst", inst, 32'd0);
        chk("rd_ipc", inst_pc, 32'd0);
        chk("rd_valid", {31'd0, inst_valid}, 32'd0);
        cyc(0, 1, 32'hE0, 0, 0, 0, 0);
        chk("rf_req", {31'd0, mem_req}, 32'd1);
        chk("rf_addr", mem_addr, 32'd0);
        chk("rf_ps", {30'd0, PS}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rf_inst", inst, 32'hE0);
        chk("rf_valid", {31'd0, inst_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
